alu_flag_unit: RTL and testbench

//  Reader/consumer side of the n-bit ALU flag outputs (Cout, V, Z, N=Fout[n-1]) in the 3-stage pipe.

---
 rtl/alu_flag_unit_pkg.sv | 41 ++++
 rtl/alu_flag_unit_if.sv | 36 +++
 rtl/alu_cond_eval.sv | 50 +++++
 rtl/alu_flag_unit.sv | 125 ++++++++++++
 tb/tb_alu_flag_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_flag_unit_pkg.sv
// ============================================================================
// Module : alu_flag_pkg
// Brief  : Condition codes, FSM states and status-flag bit positions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_flag_pkg;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  // Status register layout is {N,Z,C,V}
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EVAL = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_flag_unit_if.sv
// ============================================================================
// Module : alu_flag_unit_if
// Brief  : Flag retire, branch query and status bundle of the flag unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_flag_unit_if #(
  parameter int CC_W = 4
);
  logic            pend_inc;
  logic            flag_we;
  logic            flag_c;
  logic            flag_v;
  logic            flag_z;
  logic            flag_n;
  logic            br_valid;
  logic [CC_W-1:0] br_cond;
  logic            br_ready;
  logic            res_valid;
  logic            br_taken;
  logic [3:0]      flags_q;
  logic            pend_err;

  modport master (
    output pend_inc, flag_we, flag_c, flag_v, flag_z, flag_n, br_valid, br_cond,
    input  br_ready, res_valid, br_taken, flags_q, pend_err
  );

  modport slave (
    input  pend_inc, flag_we, flag_c, flag_v, flag_z, flag_n, br_valid, br_cond,
    output br_ready, res_valid, br_taken, flags_q, pend_err
  );
endinterface

`default_nettype wire

// File: rtl/alu_cond_eval.sv
// ============================================================================
// Module : alu_cond_eval
// Brief  : Combinational branch condition evaluation against {N,Z,C,V}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_cond_eval
  import alu_flag_pkg::*;
#(
  parameter int CC_W = 4
) (
  input  logic [CC_W-1:0] cond_i,
  input  logic [3:0]      flags_i,
  output logic            taken_o
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags_i[FLG_N];
  assign w_z = flags_i[FLG_Z];
  assign w_c = flags_i[FLG_C];
  assign w_v = flags_i[FLG_V];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CC_EQ: taken_o = w_z;
      CC_NE: taken_o = ~w_z;
      CC_CS: taken_o = w_c;
      CC_CC: taken_o = ~w_c;
      CC_MI: taken_o = w_n;
      CC_PL: taken_o = ~w_n;
      CC_VS: taken_o = w_v;
      CC_VC: taken_o = ~w_v;
      CC_HI: taken_o = w_c & ~w_z;
      CC_LS: taken_o = ~w_c | w_z;
      CC_GE: taken_o = (w_n == w_v);
      CC_LT: taken_o = (w_n != w_v);
      CC_GT: taken_o = ~w_z & (w_n == w_v);
      CC_LE: taken_o = w_z | (w_n != w_v);
      CC_AL: taken_o = 1'b1;
      CC_NV: taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_flag_unit.sv
// ============================================================================
// Module : alu_flag_unit
// Brief  : Status register, in-flight flag-write counter and branch resolver.
//          Optional FLAG_FWD_EN forwards retiring flags into a waiting query.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_flag_unit
  import alu_flag_pkg::*;
#(
  parameter int PEND_W = 2,
  parameter int CC_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  alu_flag_unit_if.slave  bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  state_t            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [3:0]        stat_q, stat_d;
  logic [CC_W-1:0]   cond_q, cond_d;
  logic              err_q, err_d;
  logic              rv_q, rv_d;
  logic              tk_q, tk_d;
  logic              hs;
  logic              fwd_hit;
  logic              eval_taken;
  logic [3:0]        flags_in;

  assign flags_in = {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
  assign hs       = bus.br_valid & (state_q == ST_IDLE);

`ifdef FLAG_FWD_EN
  assign fwd_hit = bus.flag_we & (pend_q == PEND_ONE) & ~bus.pend_inc;
`else
  assign fwd_hit = 1'b0;
`endif

  always_comb begin
    pend_d = pend_q;
    err_d  = err_q;
    stat_d = bus.flag_we ? flags_in : stat_q;
    if (bus.pend_inc && !bus.flag_we) begin
      if (pend_q == PEND_MAX) err_d = 1'b1;
      else                    pend_d = pend_q + PEND_ONE;
    end else if (bus.flag_we && !bus.pend_inc) begin
      if (pend_q == '0) err_d = 1'b1;
      else              pend_d = pend_q - PEND_ONE;
    end
  end

  // The result is registered from next-cycle flags, which equals what EVAL would read
  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    rv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          cond_d = bus.br_cond;
          if (pend_q == '0 && !bus.pend_inc) begin
            state_d = ST_EVAL;
            rv_d    = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (fwd_hit) begin
          state_d = ST_IDLE;
          rv_d    = 1'b1;
        end else if (pend_q == '0) begin
          state_d = ST_EVAL;
          rv_d    = 1'b1;
        end
      end
      ST_EVAL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    tk_d = rv_d & eval_taken;
  end

  alu_cond_eval #(
    .CC_W    (CC_W)
  ) u_eval (
    .cond_i  (cond_d),
    .flags_i (stat_d),
    .taken_o (eval_taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      stat_q  <= 4'b0000;
      cond_q  <= '0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      tk_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      stat_q  <= stat_d;
      cond_q  <= cond_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      tk_q    <= tk_d;
    end
  end

  assign bus.br_ready  = (state_q == ST_IDLE);
  assign bus.res_valid = rv_q;
  assign bus.br_taken  = tk_q;
  assign bus.flags_q   = stat_q;
  assign bus.pend_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_flag_unit.sv
// ============================================================================
// Module : tb_alu_flag_unit
// Brief  : Directed and random checks of alu_flag_unit against a cycle model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_flag_unit;

`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int PEND_MAX = 3;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  alu_flag_unit_if #(.CC_W(4)) bus ();

  alu_flag_unit #(
    .PEND_W (2),
    .CC_W   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 waiting, 2 evaluating
  int         m_phase;
  int         m_pend;
  logic [3:0] m_flags;
  logic [3:0] m_cond;
  bit         m_err;
  bit         m_fire;
  bit         m_ftk;

  function automatic bit cond_ref(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc >> 1)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit inc, input bit we,
                            input logic [3:0] f, input bit bv, input logic [3:0] cc);
    if (rst) begin
      m_phase = 0; m_pend = 0; m_flags = 4'b0; m_cond = 4'b0;
      m_err = 1'b0; m_fire = 1'b0; m_ftk = 1'b0;
      return;
    end
    m_fire = 1'b0;
    if (m_phase == 0) begin
      if (bv) begin
        m_cond  = cc;
        m_phase = (m_pend == 0 && !inc) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (FWD && we && m_pend == 1 && !inc) begin
        m_fire  = 1'b1;
        m_ftk   = cond_ref(m_cond, f);
        m_phase = 0;
      end else if (m_pend == 0) begin
        m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
    if (inc && !we) begin
      if (m_pend == PEND_MAX) m_err = 1'b1;
      else                    m_pend = m_pend + 1;
    end else if (we && !inc) begin
      if (m_pend == 0) m_err = 1'b1;
      else             m_pend = m_pend - 1;
    end
    if (we) m_flags = f;
  endtask

  // One clock: drive inputs, update model on the edge, compare at the falling edge
  task automatic cycle(input string t, input bit rst, input bit inc, input bit we,
                       input logic [3:0] f, input bit bv, input logic [3:0] cc);
    bit exp_rv, exp_tk;
    reset        = rst;
    bus.pend_inc = inc;
    bus.flag_we  = we;
    {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v} = f;
    bus.br_valid = bv;
    bus.br_cond  = cc;
    @(posedge clk);
    model_step(rst, inc, we, f, bv, cc);
    @(negedge clk);
    exp_rv = (m_phase == 2) || m_fire;
    exp_tk = (m_phase == 2) ? cond_ref(m_cond, m_flags) : (m_fire ? m_ftk : 1'b0);
    check({t, ".ready"},     32'(bus.br_ready),  32'(m_phase == 0));
    check({t, ".res_valid"}, 32'(bus.res_valid), 32'(exp_rv));
    check({t, ".br_taken"},  32'(bus.br_taken),  32'(exp_tk));
    check({t, ".flags_q"},   32'(bus.flags_q),   32'(m_flags));
    check({t, ".pend_err"},  32'(bus.pend_err),  32'(m_err));
  endtask

  task automatic idle(input string t);
    cycle(t, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic do_reset();
    cycle("rst", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    cycle("rst", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.pend_inc = 1'b0; bus.flag_we = 1'b0;
    bus.flag_c = 1'b0; bus.flag_v = 1'b0; bus.flag_z = 1'b0; bus.flag_n = 1'b0;
    bus.br_valid = 1'b0; bus.br_cond = 4'h0;

    do_reset();
    idle("post_rst");
    check("reset_flags", 32'(bus.flags_q), 32'h0);
    check("reset_ready", 32'(bus.br_ready), 32'h1);
    check("reset_err",   32'(bus.pend_err), 32'h0);

    // All 16 codes against all 16 flag combinations; inc+we together leaves pend at 0
    for (int f = 0; f < 16; f++) begin
      cycle("tbl_set", 1'b0, 1'b1, 1'b1, 4'(f), 1'b0, 4'h0);
      for (int cc = 0; cc < 16; cc++) begin
        cycle("tbl_q", 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'(cc));
        check("tbl_rv", 32'(bus.res_valid), 32'h1);
        check("tbl_taken", 32'(bus.br_taken), 32'(cond_ref(4'(cc), 4'(f))));
        idle("tbl_idle");
      end
    end

    // Idle queries with only Z set
    cycle("z_set", 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 4'h0);
    cycle("eq_q", 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd0);
    check("eq_rv", 32'(bus.res_valid), 32'h1);
    check("eq_taken", 32'(bus.br_taken), 32'h1);
    idle("eq_idle");
    cycle("ne_q", 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd1);
    check("ne_rv", 32'(bus.res_valid), 32'h1);
    check("ne_taken", 32'(bus.br_taken), 32'h0);
    idle("ne_idle");

    // Stall: GE query waits behind one in-flight write that retires N=1,V=0
    cycle("st_inc", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    cycle("st_q", 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd10);
    check("st_ready_wait", 32'(bus.br_ready), 32'h0);
    idle("st_wait");
    check("st_rv_early", 32'(bus.res_valid), 32'h0);
    cycle("st_we", 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 4'h0);
    lat = 1;
    while (!bus.res_valid && lat < 6) begin
      idle("st_drain");
      lat++;
    end
    check("st_latency", 32'(lat), FWD ? 32'd1 : 32'd2);
    check("st_taken", 32'(bus.br_taken), 32'h0);
    idle("st_idle");
    idle("st_idle");

    // Counter saturation: 4th increment flags overflow and holds at 3
    for (int i = 0; i < 3; i++) cycle("cnt_inc", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    check("cnt_err0", 32'(bus.pend_err), 32'h0);
    cycle("cnt_ovf", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    check("cnt_err1", 32'(bus.pend_err), 32'h1);
    cycle("cnt_both", 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 4'h0);
    cycle("cnt_dec", 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 4'h0);
    cycle("cnt_dec", 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 4'h0);
    cycle("cnt_q", 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd2);
    check("cnt_one_left", 32'(bus.br_ready), 32'h0);
    cycle("cnt_last", 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) idle("cnt_drain");

    // Underflow: write at zero count still updates flags
    do_reset();
    cycle("uf_we", 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 4'h0);
    check("uf_err", 32'(bus.pend_err), 32'h1);
    check("uf_flags", 32'(bus.flags_q), 32'hA);
    cycle("uf_q", 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd11);
    check("uf_rv", 32'(bus.res_valid), 32'h1);
    check("uf_taken", 32'(bus.br_taken), 32'h1);
    idle("uf_idle");

    // Reset while a query is waiting drops it
    do_reset();
    cycle("rw_set", 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 4'h0);
    cycle("rw_inc", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    cycle("rw_q", 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd14);
    cycle("rw_rst", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    check("rw_rv", 32'(bus.res_valid), 32'h0);
    check("rw_flags", 32'(bus.flags_q), 32'h0);
    check("rw_ready", 32'(bus.br_ready), 32'h1);
    for (int i = 0; i < 3; i++) idle("rw_after");
    check("rw_rv_after", 32'(bus.res_valid), 32'h0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit r_inc, r_we, r_bv, r_rst;
      r_rst = ($urandom_range(0, 199) == 0);
      r_inc = ($urandom_range(0, 9) < 3);
      r_we  = (m_pend > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      r_bv  = ($urandom_range(0, 9) < 4);
      cycle("rnd", r_rst, r_inc, r_we, 4'($urandom), r_bv, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
